// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: code table, decoder and scan FSM states.
// Encoder and scan decoder both take SEG7_CODE from here so the two ends cannot drift.
package seg7_pkg;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    WAIT_SEL,
    SETTLE,
    HOLD
  } seg7_scan_state_t;

  typedef struct packed {
    logic             ok;
    logic [NIB_W-1:0] nibble;
  } seg7_dec_t;

  // Index is the nibble value, entry is {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG7_CODE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic seg7_dec_t seg7_decode(input logic [SEG_W-1:0] seg);
    seg7_dec_t res;
    res = '0;
    for (int i = 0; i < 16; i++) begin
      if (SEG7_CODE[i] == seg) begin
        res.ok     = 1'b1;
        res.nibble = NIB_W'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// Display bus (segments + digit select) and the recovered-digit outputs.
interface seg7_scan_decoder_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic [seg7_pkg::SEG_W-1:0]                  seg;
  logic [NUM_DIGITS-1:0]                       digit_sel;
  logic [seg7_pkg::NIB_W*NUM_DIGITS-1:0]       value;
  logic [NUM_DIGITS-1:0]                       digit_valid;
  logic [NUM_DIGITS-1:0]                       digit_err;
  logic                                        frame_done;
  logic                                        stale;

  modport master (
    output seg, digit_sel,
    input  value, digit_valid, digit_err, frame_done, stale
  );

  modport slave (
    input  seg, digit_sel,
    output value, digit_valid, digit_err, frame_done, stale
  );
endinterface

// File: rtl/seg7_settle_filter.sv
// Flags when the sampled bus has been identical for SETTLE_CYCLES consecutive edges.
module seg7_settle_filter #(
  parameter int unsigned WIDTH         = 11,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_change_c,
  output logic             o_stable_c
);

  localparam int unsigned    CNT_W   = $clog2(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYCLES - 1);

  logic [WIDTH-1:0] r_in_q;
  logic [CNT_W-1:0] r_cnt;

  assign o_change_c = (i_data != r_in_q);
  assign o_stable_c = !o_change_c && (r_cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_q <= '0;
      r_cnt  <= '0;
    end else begin
      r_in_q <= i_data;
      if (o_change_c) begin
        r_cnt <= '0;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers hex nibbles from a multiplexed seven-segment bus, one capture per settled dwell,
// with per-digit valid/error flags, frame completion pulse and bus staleness.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input logic                clk,
  input logic                rst_n,
  seg7_scan_decoder_if.slave bus
);

  localparam int unsigned    IN_W   = NUM_DIGITS + SEG_W;
  localparam int unsigned    TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

  seg7_scan_state_t            r_state;
  seg7_scan_state_t            w_state_next;
  logic                        w_capture;
  logic                        w_change;
  logic                        w_stable;
  logic                        w_onehot;
  seg7_dec_t                   w_dec;
  logic [NUM_DIGITS-1:0]       w_mask_set;
  logic [TO_W-1:0]             w_tcnt_next;

  logic [NIB_W*NUM_DIGITS-1:0] r_value;
  logic [NUM_DIGITS-1:0]       r_valid;
  logic [NUM_DIGITS-1:0]       r_err;
  logic [NUM_DIGITS-1:0]       r_mask;
  logic                        r_frame_done;
  logic [TO_W-1:0]             r_tcnt;
  logic                        r_stale;

  seg7_settle_filter #(
    .WIDTH         (IN_W),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_filter (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_data     ({bus.digit_sel, bus.seg}),
    .o_change_c (w_change),
    .o_stable_c (w_stable)
  );

  assign w_onehot   = (bus.digit_sel != '0) &&
                      ((bus.digit_sel & (bus.digit_sel - NUM_DIGITS'(1))) == '0);
  assign w_dec      = seg7_decode(bus.seg);
  assign w_mask_set = r_mask | bus.digit_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= WAIT_SEL;
    end else begin
      r_state <= w_state_next;
    end
  end

  // HOLD blocks a second capture until the bus moves again
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    case (r_state)
      WAIT_SEL: begin
        if (w_onehot) w_state_next = SETTLE;
      end
      SETTLE: begin
        if (!w_onehot) begin
          w_state_next = WAIT_SEL;
        end else if (w_stable) begin
          w_capture    = 1'b1;
          w_state_next = HOLD;
        end
      end
      HOLD: begin
        if (w_change) w_state_next = w_onehot ? SETTLE : WAIT_SEL;
      end
      default: w_state_next = WAIT_SEL;
    endcase
  end

  always_comb begin
    w_tcnt_next = r_tcnt;
    if (w_capture) begin
      w_tcnt_next = '0;
    end else if (r_tcnt != TO_MAX) begin
      w_tcnt_next = r_tcnt + TO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value      <= '0;
      r_valid      <= '0;
      r_err        <= '0;
      r_mask       <= '0;
      r_frame_done <= 1'b0;
      r_tcnt       <= '0;
      r_stale      <= 1'b0;
    end else begin
      r_tcnt       <= w_tcnt_next;
      r_stale      <= (w_tcnt_next == TO_MAX);
      r_frame_done <= 1'b0;
      if (w_capture) begin
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
          if (bus.digit_sel[i]) begin
            if (w_dec.ok) r_value[NIB_W*i +: NIB_W] <= w_dec.nibble;
            r_valid[i] <= w_dec.ok;
            r_err[i]   <= !w_dec.ok;
          end
        end
        // Illegal codes still count toward the frame
        if (w_mask_set == '1) begin
          r_mask       <= '0;
          r_frame_done <= 1'b1;
        end else begin
          r_mask <= w_mask_set;
        end
      end
    end
  end

  assign bus.value       = r_value;
  assign bus.digit_valid = r_valid;
  assign bus.digit_err   = r_err;
  assign bus.frame_done  = r_frame_done;
  assign bus.stale       = r_stale;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: dwell-level reference model feeds an expected-capture queue.
module tb_seg7_scan_decoder;

  localparam int unsigned ND = 4;
  localparam int unsigned SC = 4;
  localparam int unsigned TO = 50;

  typedef struct {
    int unsigned cyc;
    logic [ND-1:0] sel;
    logic [6:0]    seg;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg7_scan_decoder_if #(.NUM_DIGITS(ND)) bus ();

  seg7_scan_decoder #(
    .NUM_DIGITS     (ND),
    .SETTLE_CYCLES  (SC),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [6:0]    codes [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  ev_t           q[$];
  logic [3:0]    m_val [ND];
  logic [ND-1:0] m_valid, m_err, m_mask;
  logic          m_fd;
  int unsigned   base;
  logic [ND+6:0] last_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: applies queued captures to the model at their due cycle, then compares all outputs
  always @(negedge clk) begin
    logic [4*ND-1:0] exp_val;
    ev_t ev;
    m_fd = 1'b0;
    if (!rst_n) begin
      for (int d = 0; d < ND; d++) m_val[d] = 4'h0;
      m_valid = '0; m_err = '0; m_mask = '0;
      base = cyc;
    end else begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        ev = q.pop_front();
        check("capture_missed", 32'(ev.cyc), 32'(cyc));
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        ev = q.pop_front();
        for (int d = 0; d < ND; d++) begin
          if (ev.sel[d]) begin
            int code_idx;
            code_idx = -1;
            for (int k = 0; k < 16; k++) if (codes[k] == ev.seg) code_idx = k;
            if (code_idx >= 0) begin
              m_val[d] = 4'(code_idx); m_valid[d] = 1'b1; m_err[d] = 1'b0;
            end else begin
              m_valid[d] = 1'b0; m_err[d] = 1'b1;
            end
            m_mask[d] = 1'b1;
          end
        end
        if (m_mask == {ND{1'b1}}) begin
          m_fd = 1'b1;
          m_mask = '0;
        end
        base = cyc;
      end
    end
    for (int d = 0; d < ND; d++) exp_val[4*d +: 4] = m_val[d];
    check("value",       32'(bus.value),       32'(exp_val));
    check("digit_valid", 32'(bus.digit_valid), 32'(m_valid));
    check("digit_err",   32'(bus.digit_err),   32'(m_err));
    check("frame_done",  32'(bus.frame_done),  32'(m_fd));
    check("stale",       32'(bus.stale),       32'((cyc - base) >= TO));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One dwell: capture expected SC edges after the first edge that sees it, if held long enough
  task automatic dwell(input logic [ND-1:0] sel, input logic [6:0] seg, input int unsigned len);
    bus.digit_sel = sel;
    bus.seg       = seg;
    if ($countones(sel) == 1 && len >= SC + 1) q.push_back('{cyc + 1 + SC, sel, seg});
    last_in = {sel, seg};
    repeat (len) step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ND-1:0] s;
    logic [6:0]    g;
    bus.digit_sel = '0;
    bus.seg       = '0;
    last_in       = '0;
    rst_n         = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;

    // Scan of four digits
    dwell(4'b0001, 7'h4F, 6);
    dwell(4'b0010, 7'h66, 6);
    dwell(4'b0100, 7'h07, 6);
    dwell(4'b1000, 7'h71, 6);
    check("scan_value", 32'(bus.value), 32'h0000_F743);
    check("scan_valid", 32'(bus.digit_valid), 32'hF);

    // Glitch inside the settle window
    dwell(4'b0001, 7'h3F, 2);
    dwell(4'b0001, 7'h06, 1);
    dwell(4'b0001, 7'h3F, 6);
    check("glitch_value0", 32'(bus.value[3:0]), 32'h0);

    // Illegal code keeps the old nibble
    dwell(4'b0100, 7'h6D, 6);
    dwell(4'b0100, 7'h00, 6);
    check("illegal_value2", 32'(bus.value[11:8]), 32'h5);
    check("illegal_valid2", 32'(bus.digit_valid[2]), 32'h0);
    check("illegal_err2",   32'(bus.digit_err[2]), 32'h1);
    dwell(4'b0100, 7'h6D, 6);
    check("restore_err2", 32'(bus.digit_err[2]), 32'h0);

    // Blanking and multi-hot: no captures, FSM parked
    dwell(4'b0000, 7'h7F, 20);
    check("blank_state", 32'(dut.r_state), 32'(seg7_pkg::WAIT_SEL));
    dwell(4'b0011, 7'h7F, 20);
    check("multihot_state", 32'(dut.r_state), 32'(seg7_pkg::WAIT_SEL));

    // Staleness: long blank, then a capture clears it
    dwell(4'b0000, 7'h00, 30);
    check("stale_set", 32'(bus.stale), 32'h1);
    dwell(4'b0010, 7'h5E, 6);
    check("stale_clear", 32'(bus.stale), 32'h0);

    // Reset in the middle of a dwell (cnt=2)
    bus.digit_sel = 4'b1000;
    bus.seg       = 7'h79;
    repeat (3) step();
    rst_n = 1'b0;
    q.delete();
    #1;
    check("rst_value", 32'(bus.value), 32'h0);
    check("rst_flags", 32'({bus.digit_valid, bus.digit_err, bus.frame_done, bus.stale}), 32'h0);
    step();
    rst_n = 1'b1;
    q.push_back('{cyc + 1 + SC, 4'b1000, 7'h79});
    last_in = {4'b1000, 7'h79};
    repeat (SC + 2) step();

    // Random dwells
    for (int n = 0; n < 250; n++) begin
      do begin
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) s = '0;
        else if (r == 1) begin
          do s = ND'($urandom_range(3, 15)); while ($countones(s) < 2);
        end else s = ND'(1 << $urandom_range(0, ND - 1));
        if ($urandom_range(0, 9) < 7) g = codes[$urandom_range(0, 15)];
        else g = 7'($urandom_range(0, 127));
      end while ({s, g} == last_in);
      dwell(s, g, $urandom_range(1, 9));
    end

    if ({4'b0000, 7'h00} == last_in) dwell(4'b0000, 7'h01, SC + 3);
    else dwell(4'b0000, 7'h00, SC + 3);
    check("drain_queue", 32'(q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

Receive-side counterpart of the hex-to-seven-segment encoder: monitors a time-multiplexed seven-segment display bus and recovers the hex nibble shown on each digit. The bus consists of segment lines plus a one-hot digit select. Used for on-FPGA loopback checking of the display path and for reading externally driven displays. It debounces each digit dwell, decodes the segment pattern back to 0-F, and reports per-digit validity, decode errors, frame completion and bus staleness.

## Interface
- NUM_DIGITS, 4, number of multiplexed digits (1-8)
- SETTLE_CYCLES, 4, consecutive identical samples required before capture (≥2)
- TIMEOUT_CYCLES, 1_000_000, cycles without a capture before `stale` asserts
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- seg  in  7  segment lines, active high; seg[0]=a … seg[6]=g; synchronous to clk
- digit_sel  in  NUM_DIGITS  one-hot active digit; all-zero = blanking
- value  out  4*NUM_DIGITS  decoded nibbles; digit i at value[4i+3:4i]
- digit_valid  out  NUM_DIGITS  digit i holds a successfully decoded nibble
- digit_err  out  NUM_DIGITS  last capture of digit i was not a legal code
- frame_done  out  1  one-cycle pulse when every digit has been captured since the previous pulse
- stale  out  1  no capture for TIMEOUT_CYCLES cycles

## Operation
- Legal codes, {g..a} hex:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=67, A=77, B=7C, C=39, D=5E, E=79, F=71
- Every other pattern is illegal.
- Settle filter: `in_q` registers {digit_sel, seg} every cycle. `cnt` behaviour:
  - resets to 0 when the live inputs differ from `in_q`
  - otherwise increments, saturating at SETTLE_CYCLES-1
- FSM states:
  - WAIT_SEL: digit_sel is not one-hot. Stay here. Go to SETTLE when digit_sel becomes one-hot.
  - SETTLE: when inputs match `in_q`, `cnt`==SETTLE_CYCLES-1 and digit_sel is one-hot, capture and go to HOLD. If digit_sel stops being one-hot, go to WAIT_SEL.
  - HOLD: wait for any input change. Then go to SETTLE if digit_sel is one-hot, else WAIT_SEL. This gives at most one capture per dwell.
- Capture of digit i with a legal code:
  - write the nibble to value[i]
  - set digit_valid[i], clear digit_err[i]
  - set frame mask bit i
- Capture of digit i with an illegal code:
  - value[i] is unchanged
  - clear digit_valid[i], set digit_err[i]
  - set mask bit i (the digit still counts toward the frame)
- Frame completion: when the mask becomes all-ones, pulse frame_done and clear the mask on the same edge. Re-capturing a digit already in the mask overwrites value and flags but does not change the mask.
- Timeout counter:
  - cleared on every capture; otherwise increments, saturating at TIMEOUT_CYCLES
  - `stale` = (counter == TIMEOUT_CYCLES)
  - `stale` clears on the edge of the next capture
- Reset, asynchronous and possibly mid-dwell, clears:
  - value=0, digit_valid=0, digit_err=0, frame_done=0, stale=0
  - mask, `cnt`, timeout counter and `in_q`
  - FSM to WAIT_SEL
- After reset release, a full settle period is required before any capture.

## Timing
- Inputs change before edge 0 and are then held. Capture occurs on edge SETTLE_CYCLES; outputs are visible after that edge. Latency is SETTLE_CYCLES+1 edges.
- A glitch of any length inside the settle window restarts the count. No capture is made from unstable data.
- frame_done is asserted for exactly the one cycle following the completing capture edge.
- A digit_sel change and a segment change on the same cycle count as a single change.
- All outputs are registered. No combinational path runs from inputs to outputs.

## Structure
- Package `seg7_pkg` contains:
  - SEG7_CODE[16] constant array holding the codes above
  - function `seg7_decode(logic [6:0]) -> {ok, nibble}`
  - FSM enum `seg7_scan_state_t` {WAIT_SEL, SETTLE, HOLD}
- The encoder should adopt SEG7_CODE from the package so both ends share one definition.
- Sub-module `seg7_settle_filter` contains `in_q`, `cnt` and the stable flag, parameterised by width and SETTLE_CYCLES.
- The FSM, capture registers, mask and timeout counter stay in the top module.

## Test plan
1. Reset then scan: hold digit_sel=0001, seg=7'h4F for 6 cycles; then 0010/7'h66, 0100/7'h07, 1000/7'h71. Required: value=16'hF743, digit_valid=4'hF, one frame_done pulse after the fourth capture.
2. Glitch rejection: digit_sel=0001, seg=7'h3F, with seg toggled to 7'h06 for 1 cycle at cycle 2. Required: no capture until SETTLE_CYCLES+1 edges after the glitch ends; then value[3:0]=0.
3. Illegal code: digit 2 shows 7'h00 after previously decoding 5. Required: value[11:8] stays 5, digit_valid[2]=0, digit_err[2]=1. A later 7'h6D restores valid=1, err=0.
4. Blanking and multi-hot: digit_sel=0000 or 0011 held for 20 cycles. Required: no capture and no frame_done, FSM in WAIT_SEL.
5. Staleness with TIMEOUT_CYCLES=50: no dwells for 50 cycles. Required: stale=1 at cycle 50 and 0 after the next capture.
6. Mid-dwell reset: rst_n low for 1 cycle at cnt=2. Required: all outputs 0 immediately; capture then needs a full SETTLE_CYCLES+1 edges after release.
